// File: rtl/regfile_seq_pkg.sv
// Shared types and opcode helpers for the processing-unit 2 register-file sequencer.
// Imported by the sequencer top and its ALU.
package regfile_seq_pkg;

   localparam int unsigned ADR_W = 2;
   localparam int unsigned DAT_W = 4;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_LDI = 3'b001,
      OP_MOV = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100,
      OP_AND = 3'b101,
      OP_OR  = 3'b110,
      OP_XOR = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Arithmetic and logic ops touch the flags; LDI/MOV/NOP leave them alone.
   function automatic logic flags_update(input opcode_t op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_XOR);
   endfunction

   function automatic logic writes_back(input opcode_t op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: M-bit result, zero/carry and a flag-update enable.
// Arithmetic runs at M+1 bits so bit M is the carry (no-borrow for SUB).
module seq_alu
   import regfile_seq_pkg::*;
#(
   parameter int unsigned M = DAT_W
) (
   input  opcode_t        op,
   input  logic [M-1:0]   a,
   input  logic [M-1:0]   b,
   input  logic [M-1:0]   imm,
   output logic [M-1:0]   result,
   output logic           z,
   output logic           c,
   output logic           flag_en
);

   logic [M:0] sum;

   always_comb begin
      sum    = '0;
      result = '0;
      c      = 1'b0;
      case (op)
         OP_LDI: result = imm;
         OP_MOV: result = a;
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[M-1:0];
            c      = sum[M];
         end
         OP_SUB: begin
            sum    = {1'b0, a} + {1'b0, ~b} + (M+1)'(1);
            result = sum[M-1:0];
            c      = sum[M];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         default: result = '0;
      endcase
      z       = (result == '0);
      flag_en = flags_update(op);
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequencer for processing unit 2: accepts one instruction, reads A/B, executes and
// writes back through port D of the two-read/one-write register file; keeps Z/C flags.
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int unsigned N = ADR_W,
   parameter int unsigned M = DAT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [2:0]   instr_op,
   input  logic [N-1:0] instr_d,
   input  logic [N-1:0] instr_a,
   input  logic [N-1:0] instr_b,
   input  logic [M-1:0] instr_imm,
   output logic [N-1:0] A_adr,
   output logic [N-1:0] B_adr,
   input  logic [M-1:0] A_dat,
   input  logic [M-1:0] B_dat,
   output logic         Write,
   output logic [N-1:0] D_adr,
   output logic [M-1:0] D_dat,
   output logic         done,
   output logic         flag_z,
   output logic         flag_c
);

   state_t        state_q;
   opcode_t       op_q;
   logic [N-1:0]  d_q, a_q, b_q;
   logic [M-1:0]  imm_q, opa_q, opb_q, res_q;
   logic          ready_q, write_q, done_q, z_q, c_q;

   logic [M-1:0]  res_d;
   logic          z_d, c_d, flag_en_d;

   seq_alu #(.M(M)) u_alu (
      .op      (op_q),
      .a       (opa_q),
      .b       (opb_q),
      .imm     (imm_q),
      .result  (res_d),
      .z       (z_d),
      .c       (c_d),
      .flag_en (flag_en_d)
   );

   // Four-cycle instruction FSM; every output comes straight from a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         d_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         ready_q <= 1'b1;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  op_q    <= opcode_t'(instr_op);
                  d_q     <= instr_d;
                  a_q     <= instr_a;
                  b_q     <= instr_b;
                  imm_q   <= instr_imm;
                  ready_q <= 1'b0;
                  state_q <= READ;
               end
            end
            READ: begin
               opa_q   <= A_dat;
               opb_q   <= B_dat;
               state_q <= EXEC;
            end
            EXEC: begin
               res_q <= res_d;
               if (flag_en_d) begin
                  z_q <= z_d;
                  c_q <= c_d;
               end
               write_q <= writes_back(op_q);
               done_q  <= 1'b1;
               state_q <= WRITE;
            end
            WRITE: begin
               write_q <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign A_adr       = a_q;
   assign B_adr       = b_q;
   assign D_adr       = d_q;
   assign D_dat       = res_q;
   assign Write       = write_q;
   assign done        = done_q;
   assign flag_z      = z_q;
   assign flag_c      = c_q;

endmodule
